// File: rtl/seg7_time_display.sv
// seg7_time_display: scans a 4-digit, multiplexed, active-low 7-segment display as MM.SS.
// Binary seconds/minutes are snapshotted once per scan frame and converted to BCD.
// Each digit dwell opens with a short all-off gap to suppress ghosting.
// Optional macro SEG7_COLON_BLINK_EN: when defined, the digit-2 decimal point blinks
// with even snapshot seconds. When it is undefined, dp stays off.
module seg7_time_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int             PW        = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  LAST      = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]  BLANK_LIM = PW'(BLANK_CYC);
    localparam logic [6:0]     SEG_OFF   = 7'h7F;
    localparam logic [6:0]     SEG_DASH  = 7'h3F;

    // Active-low glyphs for 0-9, bit 0 = segment a.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_OFF;
        endcase
    endfunction

    // Tens digit by comparison ladder; only meaningful for 0..59.
    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        if (v >= 6'd60)      return 4'd6;
        else if (v >= 6'd50) return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [5:0] v);
        return 4'(v - 6'd10 * {2'b00, bcd_tens(v)});
    endfunction

    // Stage 0: scan state and the per-frame snapshot.
    logic [PW-1:0] prescaler_p0;
    logic [1:0]    digit_sel_p0;
    logic [5:0]    snap_sec_p0;
    logic [5:0]    snap_min_p0;
    logic          vld_p0;

    logic wrap;
    logic snap_now;

    assign wrap     = (prescaler_p0 == LAST);
    assign snap_now = wrap && (digit_sel_p0 == 2'd3);

    // Advance the prescaler and digit select; latch the inputs at the end of digit 3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler_p0 <= '0;
            digit_sel_p0 <= 2'd0;
            snap_sec_p0  <= 6'd0;
            snap_min_p0  <= 6'd0;
            vld_p0       <= 1'b0;
        end else begin
            if (wrap) begin
                prescaler_p0 <= '0;
                digit_sel_p0 <= digit_sel_p0 + 2'd1;
            end else begin
                prescaler_p0 <= prescaler_p0 + 1'b1;
            end
            vld_p0 <= snap_now;
            if (snap_now) begin
                snap_sec_p0 <= seconds;
                snap_min_p0 <= minutes;
            end
        end
    end

    logic [6:0] seg_d;
    logic [3:0] an_d;
    logic       dp_d;
    logic       blank;
    logic       sec_oor;
    logic       min_oor;

    assign blank   = (prescaler_p0 < BLANK_LIM);
    assign sec_oor = (snap_sec_p0 > 6'd59);
    assign min_oor = (snap_min_p0 > 6'd59);

    // Decode the selected digit of the snapshot into anode, segment and dp levels.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = 4'hF;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d = ~(4'b0001 << digit_sel_p0);
            case (digit_sel_p0)
                2'd0:    seg_d = sec_oor ? SEG_DASH : glyph(bcd_ones(snap_sec_p0));
                2'd1:    seg_d = sec_oor ? SEG_DASH : glyph(bcd_tens(snap_sec_p0));
                2'd2:    seg_d = min_oor ? SEG_DASH : glyph(bcd_ones(snap_min_p0));
                default: seg_d = min_oor ? SEG_DASH : glyph(bcd_tens(snap_min_p0));
            endcase
`ifdef SEG7_COLON_BLINK_EN
            dp_d = !((digit_sel_p0 == 2'd2) && !snap_sec_p0[0] && !sec_oor);
`else
            dp_d = 1'b1;
`endif
        end
    end

    // Stage 1: registered display drive; frame_start lines up with digit 0's blank cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg         <= SEG_OFF;
            an          <= 4'hF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_d;
            an          <= an_d;
            dp          <= dp_d;
            frame_start <= vld_p0;
        end
    end

endmodule

// File: tb/tb_seg7_time_display.sv
// Directed testbench for seg7_time_display with REFRESH_DIV=4, BLANK_CYC=1 (16-cycle frame).
module tb_seg7_time_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

`ifdef SEG7_COLON_BLINK_EN
    localparam bit COLON = 1'b1;
`else
    localparam bit COLON = 1'b0;
`endif

    seg7_time_display #(.REFRESH_DIV(4), .BLANK_CYC(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .seconds     (seconds),
        .minutes     (minutes),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic bit dp2_on(input int s);
        return COLON && ((s % 2) == 0) && (s <= 59);
    endfunction

    // Check 16 consecutive samples of one frame; current negedge sample is k=0.
    task automatic check_frame(input string name, input logic [6:0] g0, input logic [6:0] g1,
                               input logic [6:0] g2, input logic [6:0] g3, input bit dp2,
                               input bit fs_first, input int mid_k, input logic [5:0] mid_sec);
        logic [6:0] gl [4];
        logic [3:0] one;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fs;
        int         d;
        bit         blank;
        gl  = '{g0, g1, g2, g3};
        one = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (k == mid_k) seconds = mid_sec;
            d     = k / 4;
            blank = (k % 4) == 0;
            e_an  = blank ? 4'hF : ~(one << d);
            e_seg = blank ? 7'h7F : gl[d];
            e_dp  = (!blank && d == 2 && dp2) ? 1'b0 : 1'b1;
            e_fs  = (k == 0) ? fs_first : 1'b0;
            checks++;
            if (an !== e_an) begin
                errors++;
                $display("FAIL %s k=%0d an: got %h expected %h", name, k, an, e_an);
            end
            checks++;
            if (seg !== e_seg) begin
                errors++;
                $display("FAIL %s k=%0d seg: got %h expected %h", name, k, seg, e_seg);
            end
            checks++;
            if (dp !== e_dp) begin
                errors++;
                $display("FAIL %s k=%0d dp: got %b expected %b", name, k, dp, e_dp);
            end
            checks++;
            if (frame_start !== e_fs) begin
                errors++;
                $display("FAIL %s k=%0d frame_start: got %b expected %b", name, k, frame_start, e_fs);
            end
        end
    endtask

    // Advance to the next negedge sample showing frame_start, within a cycle budget.
    task automatic wait_fs(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s wait_frame_start: got timeout expected pulse within 40 cycles", name);
        end
    endtask

    task automatic test_reset;
        reset   = 1'b0;
        seconds = 6'd0;
        minutes = 6'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d: got an=%h seg=%h dp=%b fs=%b expected an=f seg=7f dp=1 fs=0",
                         i, an, seg, dp, frame_start);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        check_frame("post_reset", 7'h40, 7'h40, 7'h40, 7'h40, dp2_on(0), 1'b0, -1, 6'd0);
    endtask

    task automatic test_digits;
        seconds = 6'd37;
        minutes = 6'd12;
        wait_fs("digits_sync");
        wait_fs("digits");
        check_frame("digits_37_12", 7'h78, 7'h30, 7'h24, 7'h79, dp2_on(37), 1'b1, -1, 6'd0);
    endtask

    task automatic test_no_tear;
        wait_fs("no_tear");
        check_frame("no_tear_37", 7'h78, 7'h30, 7'h24, 7'h79, dp2_on(37), 1'b1, 6, 6'd38);
        @(negedge clk);
        check_frame("after_tear_38", 7'h00, 7'h30, 7'h24, 7'h79, dp2_on(38), 1'b1, -1, 6'd0);
    endtask

    task automatic test_out_of_range;
        seconds = 6'd5;
        minutes = 6'd60;
        wait_fs("oor_sync");
        wait_fs("oor");
        check_frame("oor_min60", 7'h12, 7'h40, 7'h3F, 7'h3F, dp2_on(5), 1'b1, -1, 6'd0);
    endtask

    task automatic test_reset_mid;
        seconds = 6'd37;
        minutes = 6'd12;
        wait_fs("rst_mid_sync");
        wait_fs("rst_mid");
        repeat (9) @(negedge clk);
        checks++;
        if (an !== 4'hB || seg !== 7'h24) begin
            errors++;
            $display("FAIL rst_mid_pre: got an=%h seg=%h expected an=b seg=24", an, seg);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got an=%h seg=%h dp=%b fs=%b expected an=f seg=7f dp=1 fs=0",
                     an, seg, dp, frame_start);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_frame("rst_mid_restart", 7'h40, 7'h40, 7'h40, 7'h40, dp2_on(0), 1'b0, -1, 6'd0);
    endtask

    task automatic test_colon;
        seconds = 6'd10;
        minutes = 6'd0;
        wait_fs("colon10_sync");
        wait_fs("colon10");
        check_frame("colon_sec10", 7'h40, 7'h79, 7'h40, 7'h40, dp2_on(10), 1'b1, -1, 6'd0);
        seconds = 6'd11;
        wait_fs("colon11_sync");
        wait_fs("colon11");
        check_frame("colon_sec11", 7'h79, 7'h79, 7'h40, 7'h40, dp2_on(11), 1'b1, -1, 6'd0);
    endtask

    initial begin
        test_reset();
        test_digits();
        test_no_tear();
        test_out_of_range();
        test_reset_mid();
        test_colon();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
